// File: rtl/neopixel_tx.sv
// WS2812 single-wire line driver: serialises 24-bit GRB words MSB first with
// programmable bit timing, a one-word prefetch buffer, a latch gap and an optional sleep gap.
module neopixel_tx #(
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [CntWidth-1:0] num_neopixel_i,
  input  logic [CntWidth-1:0] t1h_i,
  input  logic [CntWidth-1:0] t1l_i,
  input  logic [CntWidth-1:0] t0h_i,
  input  logic [CntWidth-1:0] t0l_i,
  input  logic [CntWidth-1:0] t_latch_i,
  input  logic [CntWidth-1:0] sleep_i,
  input  logic                pixel_valid_i,
  input  logic [23:0]         pixel_data_i,
  output logic                pixel_ready_o,
  output logic                data_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic                underrun_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HIGH,
    LOW,
    LATCH,
    SLEEP
  } state_e;

  localparam logic [CntWidth-1:0] One = CntWidth'(1);

  state_e              state_q;

  // Frame-constant copies of the timing inputs, taken when a frame starts.
  logic [CntWidth-1:0] num_q;
  logic [CntWidth-1:0] t1h_q;
  logic [CntWidth-1:0] t1l_q;
  logic [CntWidth-1:0] t0h_q;
  logic [CntWidth-1:0] t0l_q;
  logic [CntWidth-1:0] latch_q;
  logic [CntWidth-1:0] sleep_q;

  logic [23:0]         next_q;
  logic                next_vld_q;
  logic [23:0]         shift_q;
  logic [4:0]          bit_cnt_q;
  logic [CntWidth-1:0] fetched_q;
  logic [CntWidth-1:0] sent_q;
  logic [CntWidth-1:0] dur_q;

  logic                data_q;
  logic                frame_done_q;
  logic                underrun_q;

  logic                handshake;
  logic [CntWidth-1:0] load_dur;
  logic [CntWidth-1:0] next_bit_dur;
  logic [CntWidth-1:0] low_dur;

  // Counter preload for a duration d: max(d,1)-1, so a zero duration still lasts one cycle.
  function automatic logic [CntWidth-1:0] last_cnt(input logic [CntWidth-1:0] d);
    return (d == '0) ? '0 : d - One;
  endfunction

  assign pixel_ready_o = (state_q != IDLE) && !next_vld_q && (fetched_q < num_q);
  assign handshake     = pixel_valid_i && pixel_ready_o;

  assign load_dur      = last_cnt(next_q[23]  ? t1h_q : t0h_q);
  assign next_bit_dur  = last_cnt(shift_q[22] ? t1h_q : t0h_q);
  assign low_dur       = last_cnt(shift_q[23] ? t1l_q : t0l_q);

  assign data_o        = data_q;
  assign busy_o        = (state_q != IDLE);
  assign frame_done_o  = frame_done_q;
  assign underrun_o    = underrun_q;

  // NOTE: every register here is assigned with <= so all flops update from the
  // same pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: reset is synchronous, so it only takes effect on a clock edge; every
      // flop, including the prefetch word and shadows, is cleared so no stale pixel survives.
      state_q      <= IDLE;
      num_q        <= '0;
      t1h_q        <= '0;
      t1l_q        <= '0;
      t0h_q        <= '0;
      t0l_q        <= '0;
      latch_q      <= '0;
      sleep_q      <= '0;
      next_q       <= '0;
      next_vld_q   <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      fetched_q    <= '0;
      sent_q       <= '0;
      dur_q        <= '0;
      data_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;

      // Ready is low whenever next_vld_q is set, so a fill never collides with a load below.
      if (handshake) begin
        next_q     <= pixel_data_i;
        next_vld_q <= 1'b1;
        fetched_q  <= fetched_q + One;
      end

      case (state_q)
        IDLE: begin
          data_q <= 1'b0;
          if (enable_i && (num_neopixel_i != '0)) begin
            num_q      <= num_neopixel_i;
            t1h_q      <= t1h_i;
            t1l_q      <= t1l_i;
            t0h_q      <= t0h_i;
            t0l_q      <= t0l_i;
            latch_q    <= t_latch_i;
            sleep_q    <= sleep_i;
            fetched_q  <= '0;
            sent_q     <= '0;
            next_vld_q <= 1'b0;
            state_q    <= WAIT;
          end
        end

        WAIT: begin
          data_q <= 1'b0;
          if (next_vld_q) begin
            shift_q    <= next_q;
            next_vld_q <= 1'b0;
            bit_cnt_q  <= 5'd23;
            dur_q      <= load_dur;
            data_q     <= 1'b1;
            state_q    <= HIGH;
          end
        end

        HIGH: begin
          if (dur_q == '0) begin
            dur_q   <= low_dur;
            data_q  <= 1'b0;
            state_q <= LOW;
          end else begin
            dur_q <= dur_q - One;
          end
        end

        LOW: begin
          if (dur_q != '0) begin
            dur_q <= dur_q - One;
          end else if (bit_cnt_q != 5'd0) begin
            shift_q   <= {shift_q[22:0], 1'b0};
            bit_cnt_q <= bit_cnt_q - 5'd1;
            dur_q     <= next_bit_dur;
            data_q    <= 1'b1;
            state_q   <= HIGH;
          end else begin
            sent_q <= sent_q + One;
            if (sent_q + One == num_q) begin
              dur_q   <= last_cnt(latch_q);
              state_q <= LATCH;
            end else if (next_vld_q) begin
              // Back-to-back pixel: the first high cycle follows the last low cycle directly.
              shift_q    <= next_q;
              next_vld_q <= 1'b0;
              bit_cnt_q  <= 5'd23;
              dur_q      <= load_dur;
              data_q     <= 1'b1;
              state_q    <= HIGH;
            end else begin
              underrun_q <= 1'b1;
              state_q    <= WAIT;
            end
          end
        end

        LATCH: begin
          if (dur_q != '0) begin
            dur_q <= dur_q - One;
          end else if (sleep_q == '0) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            dur_q   <= sleep_q - One;
            state_q <= SLEEP;
          end
        end

        SLEEP: begin
          if (dur_q != '0) begin
            dur_q <= dur_q - One;
          end else begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end

        default: begin
          data_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_tx.sv
// Directed bench for neopixel_tx: captures per-cycle outputs after starting a frame
// and compares them against hand-derived waveforms and event cycles.
module tb_neopixel_tx;

  localparam int SelData = 0;
  localparam int SelFd   = 1;
  localparam int SelUr   = 2;
  localparam int SelHs   = 3;
  localparam int SelBusy = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] num;
  logic [31:0] t1h, t1l, t0h, t0l, t_latch, sleep;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic        pixel_ready;
  logic        data;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic d_cap    [512];
  logic fd_cap   [512];
  logic ur_cap   [512];
  logic rdy_cap  [512];
  logic busy_cap [512];
  logic hs_cap   [512];
  logic exp_d    [512];

  logic [23:0] words [8];
  int nwords;
  int stall_lo, stall_hi;
  int rst_at;
  int chg_at;
  logic [31:0] chg_val;
  int e;

  neopixel_tx #(.CntWidth(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .num_neopixel_i(num),
    .t1h_i         (t1h),
    .t1l_i         (t1l),
    .t0h_i         (t0h),
    .t0l_i         (t0l),
    .t_latch_i     (t_latch),
    .sleep_i       (sleep),
    .pixel_valid_i (pixel_valid),
    .pixel_data_i  (pixel_data),
    .pixel_ready_o (pixel_ready),
    .data_o        (data),
    .busy_o        (busy),
    .frame_done_o  (frame_done),
    .underrun_o    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // Expected line waveform for one pixel starting at cycle start; returns the next free cycle.
  function automatic int add_pixel(input logic [23:0] w, input int start,
                                   input int h1, input int l1, input int h0, input int l0);
    int c;
    c = start;
    for (int b = 23; b >= 0; b--) begin
      for (int k = 0; k < eff(w[b] ? h1 : h0); k++) begin exp_d[c] = 1'b1; c++; end
      for (int k = 0; k < eff(w[b] ? l1 : l0); k++) begin exp_d[c] = 1'b0; c++; end
    end
    return c;
  endfunction

  function automatic logic pick(input int sel, input int c);
    case (sel)
      SelData: return d_cap[c];
      SelFd:   return fd_cap[c];
      SelUr:   return ur_cap[c];
      SelHs:   return hs_cap[c];
      default: return busy_cap[c];
    endcase
  endfunction

  function automatic int count_in(input int sel, input int lo, input int hi);
    int n;
    n = 0;
    for (int c = lo; c <= hi; c++) if (pick(sel, c) === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_in(input int sel, input int from);
    for (int c = from; c < 512; c++) if (pick(sel, c) === 1'b1) return c;
    return -1;
  endfunction

  function automatic int wave_err(input int n);
    int m;
    m = 0;
    for (int c = 1; c <= n; c++) if (d_cap[c] !== exp_d[c]) m++;
    return m;
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 512; i++) exp_d[i] = 1'b0;
  endtask

  task automatic defaults();
    nwords   = 0;
    stall_lo = -1;
    stall_hi = -1;
    rst_at   = -1;
    chg_at   = -1;
    chg_val  = '0;
  endtask

  // Called at a falling edge with the DUT idle; cycle 0 is the cycle enable is sampled in.
  task automatic run(input int n, input bit hold);
    int hs;
    hs = 0;
    for (int i = 0; i < 512; i++) begin
      d_cap[i] = 0; fd_cap[i] = 0; ur_cap[i] = 0;
      rdy_cap[i] = 0; busy_cap[i] = 0; hs_cap[i] = 0;
    end
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        @(negedge clk);
        d_cap[c]    = data;
        fd_cap[c]   = frame_done;
        ur_cap[c]   = underrun;
        rdy_cap[c]  = pixel_ready;
        busy_cap[c] = busy;
      end
      enable = (c == 0) ? 1'b1 : hold;
      rst    = (c == rst_at);
      if (c == chg_at) t1h = chg_val;
      pixel_valid = (hs < nwords) && !(c >= stall_lo && c < stall_hi);
      pixel_data  = words[(hs < 8) ? hs : 7];
      hs_cap[c]   = pixel_valid && pixel_ready;
      if (hs_cap[c]) hs++;
    end
    enable      = 1'b0;
    pixel_valid = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    pixel_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; num = 0;
    t1h = 0; t1l = 0; t0h = 0; t0l = 0; t_latch = 0; sleep = 0;
    pixel_valid = 1'b0; pixel_data = '0;
    for (int i = 0; i < 8; i++) words[i] = '0;
    defaults();

    // Reset state
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_data",     64'(data),        64'd0);
    check("rst_ready",    64'(pixel_ready), 64'd0);
    check("rst_busy",     64'(busy),        64'd0);
    check("rst_done",     64'(frame_done),  64'd0);
    check("rst_underrun", 64'(underrun),    64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single pixel basic waveform
    defaults();
    num = 1; t1h = 3; t1l = 2; t0h = 1; t0l = 4; t_latch = 5; sleep = 0;
    words[0] = 24'hA00000; nwords = 1;
    clear_exp();
    e = add_pixel(24'hA00000, 3, 3, 2, 1, 4);
    run(130, 1'b0);
    check("t1_ready_c1",  64'(rdy_cap[1]),                64'd1);
    check("t1_ready_c2",  64'(rdy_cap[2]),                64'd0);
    check("t1_first_rise", 64'(first_in(SelData, 1)),     64'd3);
    check("t1_wave_errs", 64'(wave_err(130)),             64'd0);
    check("t1_high_cyc",  64'(count_in(SelData, 1, 130)), 64'd28);
    check("t1_done_cyc",  64'(first_in(SelFd, 1)),        64'd128);
    check("t1_done_cnt",  64'(count_in(SelFd, 1, 130)),   64'd1);
    check("t1_busy_127",  64'(busy_cap[127]),             64'd1);
    check("t1_busy_128",  64'(busy_cap[128]),             64'd0);

    // Zero-duration clamp
    defaults();
    num = 1; t1h = 3; t1l = 2; t0h = 0; t0l = 0; t_latch = 0; sleep = 0;
    words[0] = 24'h000000; nwords = 1;
    clear_exp();
    e = add_pixel(24'h000000, 3, 3, 2, 0, 0);
    run(60, 1'b0);
    check("t2_wave_errs", 64'(wave_err(60)),       64'd0);
    check("t2_done_cyc",  64'(first_in(SelFd, 1)), 64'd52);

    // Back-to-back pixels and frames
    defaults();
    num = 3; t1h = 2; t1l = 1; t0h = 1; t0l = 2; t_latch = 4; sleep = 7;
    words[0] = 24'h123456; words[1] = 24'hABCDEF; words[2] = 24'h00FF00;
    words[3] = 24'h123456; words[4] = 24'hABCDEF; words[5] = 24'h00FF00;
    nwords = 6;
    clear_exp();
    e = add_pixel(words[0], 3, 2, 1, 1, 2);
    e = add_pixel(words[1], e, 2, 1, 1, 2);
    e = add_pixel(words[2], e, 2, 1, 1, 2);
    run(240, 1'b1);
    check("t3_wave_errs",   64'(wave_err(229)),            64'd0);
    check("t3_handshakes",  64'(count_in(SelHs, 0, 229)),  64'd3);
    check("t3_done_cyc",    64'(first_in(SelFd, 1)),       64'd230);
    check("t3_busy_230",    64'(busy_cap[230]),            64'd0);
    check("t3_busy_231",    64'(busy_cap[231]),            64'd1);
    check("t3_frame2_rise", 64'(first_in(SelData, 230)),   64'd233);
    do_reset();

    // Underrun on the second pixel
    defaults();
    num = 2; t1h = 1; t1l = 1; t0h = 1; t0l = 1; t_latch = 2; sleep = 0;
    words[0] = 24'hF0F0F0; words[1] = 24'h0F0F0F; nwords = 2;
    stall_lo = 2; stall_hi = 61;
    clear_exp();
    e = add_pixel(words[0], 3, 1, 1, 1, 1);
    e = add_pixel(words[1], 63, 1, 1, 1, 1);
    run(120, 1'b0);
    check("t4_wave_errs",  64'(wave_err(120)),             64'd0);
    check("t4_stall_low",  64'(count_in(SelData, 51, 62)), 64'd0);
    check("t4_ur_cnt",     64'(count_in(SelUr, 1, 120)),   64'd1);
    check("t4_ur_cyc",     64'(first_in(SelUr, 1)),        64'd51);
    check("t4_done_cyc",   64'(first_in(SelFd, 1)),        64'd113);

    // Reset during the first high phase, then a fresh frame
    defaults();
    num = 2; t1h = 5; t1l = 1; t0h = 1; t0l = 1; t_latch = 1; sleep = 0;
    words[0] = 24'h800000; words[1] = 24'h800000; nwords = 2;
    rst_at = 5;
    run(20, 1'b0);
    check("t5_high_c5",   64'(d_cap[5]),                  64'd1);
    check("t5_data_c6",   64'(d_cap[6]),                  64'd0);
    check("t5_busy_c6",   64'(busy_cap[6]),               64'd0);
    check("t5_ready_c6",  64'(rdy_cap[6]),                64'd0);
    check("t5_quiet",     64'(count_in(SelData, 6, 20)),  64'd0);
    check("t5_no_done",   64'(count_in(SelFd, 1, 20)),    64'd0);
    defaults();
    num = 1; words[0] = 24'h800000; nwords = 1;
    clear_exp();
    e = add_pixel(24'h800000, 3, 5, 1, 1, 1);
    run(60, 1'b0);
    check("t5_replay_wave", 64'(wave_err(60)),       64'd0);
    check("t5_replay_done", 64'(first_in(SelFd, 1)), 64'd56);

    // num = 0 with enable held
    defaults();
    num = 0; words[0] = 24'hFFFFFF; nwords = 1;
    run(10, 1'b1);
    check("t6_num0_busy", 64'(count_in(SelBusy, 1, 10)), 64'd0);
    check("t6_num0_hs",   64'(count_in(SelHs, 0, 10)),   64'd0);

    // Mid-frame timing change is ignored
    defaults();
    num = 1; t1h = 3; t1l = 1; t0h = 1; t0l = 1; t_latch = 1; sleep = 0;
    words[0] = 24'hFFFFFF; nwords = 1;
    chg_at = 5; chg_val = 9;
    clear_exp();
    e = add_pixel(24'hFFFFFF, 3, 3, 1, 1, 1);
    run(110, 1'b0);
    check("t6_chg_wave", 64'(wave_err(110)),      64'd0);
    check("t6_chg_done", 64'(first_in(SelFd, 1)), 64'd100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
